// File: rtl/dbus_arbiter_if.sv
// -----------------------------------------------------------------------------
// dbus_pkg / dbus_arbiter_if
//
// Purpose:
//   Shared data-bus types plus the interface bundling every bus-side signal of
//   the two-master data-bus arbiter.
//
// Handshake (valid/ready semantics, one place for all of it):
//   A master raises req.valid with a stable payload and keeps it until it sees
//   resp.data_ok. data_ok is a one-cycle completion pulse; the master drops
//   valid on the cycle after it (registered deassert). addr_ok is passed
//   through for masters that want the address-phase acknowledge. A read is a
//   request with strobe == 0.
//
// Interface signals:
//   m0_req / m0_resp   master 0 (load/store unit) request and response
//   m1_req / m1_resp   master 1 (secondary requester) request and response
//   s_req / s_resp     single downstream slave port
//   grant              one-hot owner: 01 = m0, 10 = m1, 00 = none
//   timeout_err        sticky watchdog flag
//   state_dbg          arbiter FSM state (0 = IDLE, 1 = BUSY, 2 = COOL)
//
// Modports:
//   slave  - the arbiter's view (it serves the two masters)
//   master - the environment's view (drives master requests and slave response)
// -----------------------------------------------------------------------------
package dbus_pkg;
    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

interface dbus_arbiter_if;
    import dbus_pkg::*;

    dbus_req_t  m0_req;
    dbus_resp_t m0_resp;
    dbus_req_t  m1_req;
    dbus_resp_t m1_resp;
    dbus_req_t  s_req;
    dbus_resp_t s_resp;
    logic [1:0] grant;
    logic       timeout_err;
    logic [1:0] state_dbg;

    modport slave (
        input  m0_req, m1_req, s_resp,
        output m0_resp, m1_resp, s_req, grant, timeout_err, state_dbg
    );

    modport master (
        output m0_req, m1_req, s_resp,
        input  m0_resp, m1_resp, s_req, grant, timeout_err, state_dbg
    );
endinterface

// File: rtl/dbus_arbiter.sv
// -----------------------------------------------------------------------------
// dbus_arbiter
//
// Purpose:
//   Shares one data-bus slave port between master 0 (memory-stage LSU) and
//   master 1 (page walker / debug). The winning request is latched into a
//   fully registered slave request and held until the slave returns data_ok.
//   The slave response is routed back to the owning master only.
//
// Ports:
//   clk      in   system clock, all state updates on posedge
//   reset_n  in   asynchronous active-low reset
//   dbus     bus  dbus_arbiter_if.slave: m0/m1 request+response, slave
//                 request+response, grant, timeout_err, state_dbg
//
// Parameters:
//   ROUND_ROBIN     1 = alternate on ties, 0 = master 0 always wins ties
//   TIMEOUT_CYCLES  BUSY cycles without data_ok before timeout_err; 0 = off
//   CNT_W           watchdog counter width, 2^CNT_W > TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module dbus_arbiter #(
    parameter bit ROUND_ROBIN    = 1'b1,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input logic           clk,
    input logic           reset_n,
    dbus_arbiter_if.slave dbus
);
    import dbus_pkg::*;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_COOL = 2'd2
    } state_t;

    localparam bit               WD_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_t           r_state;
    dbus_req_t        r_s_req;
    logic [1:0]       r_grant;
    logic [1:0]       r_mask;     // one-hot master ignored during COOL
    logic             r_rr_last;  // 1 = m1 was served last
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    logic [1:0]       w_elig;
    logic             w_any;
    logic             w_pick_m1;
    dbus_req_t        w_win_req;
    logic [CNT_W-1:0] w_cnt_inc;

    // Arbitration. r_mask is only non-zero in COOL, so in IDLE every valid
    // master is eligible; in COOL the master just served is excluded because
    // its valid is still the stale copy of the completed access.
    always_comb begin
        w_elig = {dbus.m1_req.valid, dbus.m0_req.valid} & ~r_mask;
        w_any  = |w_elig;
        if (w_elig == 2'b11) begin
            w_pick_m1 = ROUND_ROBIN ? ~r_rr_last : 1'b0;
        end else begin
            w_pick_m1 = w_elig[1];
        end
        w_win_req       = w_pick_m1 ? dbus.m1_req : dbus.m0_req;
        w_win_req.valid = 1'b1;
        w_cnt_inc       = r_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_s_req   <= '0;
            r_grant   <= 2'b00;
            r_mask    <= 2'b00;
            r_rr_last <= 1'b1;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_COOL: begin
                    r_mask <= 2'b00;
                    if (w_any) begin
                        r_s_req <= w_win_req;
                        r_grant <= w_pick_m1 ? 2'b10 : 2'b01;
                        r_cnt   <= '0;
                        r_state <= ST_BUSY;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // The latched request stays put; master-side changes are
                    // not looked at until the next arbitration.
                    if (dbus.s_resp.data_ok) begin
                        r_s_req.valid <= 1'b0;
                        r_rr_last     <= r_grant[1];
                        r_mask        <= r_grant;
                        r_grant       <= 2'b00;
                        r_state       <= ST_COOL;
                    end else if (WD_EN) begin
                        // Watchdog only flags; the transaction keeps waiting.
                        if (r_cnt != TO_LIMIT) begin
                            r_cnt <= w_cnt_inc;
                        end
                        if ((r_cnt == TO_LIMIT) || (w_cnt_inc == TO_LIMIT)) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Response routing: only the owner sees the slave, and only while BUSY,
    // so a stray data_ok in IDLE/COOL never reaches a master.
    always_comb begin
        dbus.m0_resp = '0;
        dbus.m1_resp = '0;
        if (r_state == ST_BUSY) begin
            if (r_grant[0]) begin
                dbus.m0_resp = dbus.s_resp;
            end
            if (r_grant[1]) begin
                dbus.m1_resp = dbus.s_resp;
            end
        end
    end

    assign dbus.s_req       = r_s_req;
    assign dbus.grant       = r_grant;
    assign dbus.timeout_err = r_timeout;
    assign dbus.state_dbg   = r_state;

endmodule
